// File: rtl/greenhouse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : greenhouse_pkg
// Purpose  : Shared types and constants for the greenhouse climate controller.
//            Holds the controller state encoding, the actuator-mode codes and
//            small helpers that decode which actuator a mode permits.
// Revision : 1.0 - initial release
// ============================================================================
package greenhouse_pkg;

    // Controller state; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAT = 2'b01,
        ST_COOL = 2'b10,
        ST_REST = 2'b11
    } state_t;

    // Actuator mode codes as presented on the mode input.
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_HEAT = 2'b01;
    localparam logic [1:0] MODE_COOL = 2'b10;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    // Heating is allowed in heat-only and auto modes.
    function automatic logic heat_permitted(input logic [1:0] mode);
        return (mode & MODE_HEAT) != MODE_OFF;
    endfunction

    // Cooling is allowed in cool-only and auto modes.
    function automatic logic cool_permitted(input logic [1:0] mode);
        return (mode & MODE_COOL) != MODE_OFF;
    endfunction

endpackage : greenhouse_pkg
`default_nettype wire

// File: rtl/temp_alarm_debounce.sv
`default_nettype none
// ============================================================================
// Module   : temp_alarm_debounce
// Purpose  : Debounced threshold alarm. Counts consecutive valid samples that
//            are beyond THRESH (above it when ABOVE=1, below it when ABOVE=0)
//            and raises the alarm once CNT such samples have been seen in a
//            row. Any valid, non-qualifying sample clears count and alarm;
//            cycles without a valid sample leave everything untouched.
// Revision : 1.0 - initial release
// ============================================================================
module temp_alarm_debounce #(
    parameter int TEMP_W = 8,
    parameter int THRESH = 60,
    parameter int CNT    = 4,
    parameter bit ABOVE  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] temp,
    output logic              alarm
);
    import greenhouse_pkg::*;

    // Counter must be able to hold the value CNT itself.
    localparam int CW = (CNT > 0) ? $clog2(CNT + 1) : 1;
    localparam logic [CW-1:0] C_CNT_MAX = CW'(CNT);

    logic signed [31:0] w_temp_x;
    logic               w_qual;
    logic [CW-1:0]      w_cnt_next;
    logic [CW-1:0]      r_cnt;
    logic               r_alarm;

    // Sign-extend so the threshold compare is a true signed compare.
    assign w_temp_x   = 32'($signed(temp));
    assign w_qual     = ABOVE ? (w_temp_x > THRESH) : (w_temp_x < THRESH);
    assign w_cnt_next = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CW'(1);

    // Consecutive-sample counter with the alarm registered alongside it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_alarm <= 1'b0;
        end else if (sample_valid) begin
            if (w_qual) begin
                r_cnt   <= w_cnt_next;
                r_alarm <= (w_cnt_next == C_CNT_MAX);
            end else begin
                r_cnt   <= '0;
                r_alarm <= 1'b0;
            end
        end
    end

    assign alarm = r_alarm;

endmodule : temp_alarm_debounce
`default_nettype wire

// File: rtl/greenhouse_temp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : greenhouse_temp_ctrl
// Purpose  : Single-zone greenhouse climate controller. Compares a sampled
//            signed temperature with a runtime setpoint and hysteresis band,
//            drives mutually exclusive heater/cooler enables with minimum
//            on-time and mandatory rest time, and raises debounced high/low
//            temperature alarms.
// Revision : 1.0 - initial release
// ============================================================================
module greenhouse_temp_ctrl #(
    parameter int TEMP_W    = 8,
    parameter int HYST      = 2,
    parameter int MIN_ON    = 8,
    parameter int MIN_OFF   = 8,
    parameter int ALARM_HI  = 60,
    parameter int ALARM_LO  = -10,
    parameter int ALARM_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [TEMP_W-1:0] greenhouse_temp,
    input  logic [TEMP_W-1:0] setpoint,
    input  logic [1:0]        mode,
    output logic              heater_on,
    output logic              cooler_on,
    output logic [1:0]        state_o,
    output logic              alarm_hi,
    output logic              alarm_lo
);
    import greenhouse_pkg::*;

    // One extra bit so setpoint +/- HYST never wraps at the range extremes.
    localparam int XW    = TEMP_W + 1;
    localparam int ON_W  = (MIN_ON  > 1) ? $clog2(MIN_ON)  : 1;
    localparam int OFF_W = (MIN_OFF > 1) ? $clog2(MIN_OFF) : 1;
    localparam logic [ON_W-1:0]  C_ON_LAST  = ON_W'(MIN_ON - 1);
    localparam logic [OFF_W-1:0] C_OFF_LAST = OFF_W'(MIN_OFF - 1);
    localparam logic signed [XW-1:0] C_HYST = XW'(HYST);

    logic signed [XW-1:0] w_temp_x;
    logic signed [XW-1:0] w_sp_x;
    logic signed [XW-1:0] w_band_lo;
    logic signed [XW-1:0] w_band_hi;
    logic                 w_too_cold;
    logic                 w_too_hot;
    logic                 w_heat_done;
    logic                 w_cool_done;
    logic                 w_heat_ok;
    logic                 w_cool_ok;

    state_t               r_state;
    logic [ON_W-1:0]      r_on_cnt;
    logic [OFF_W-1:0]     r_off_cnt;
    logic                 r_heater;
    logic                 r_cooler;

    assign w_temp_x  = {greenhouse_temp[TEMP_W-1], greenhouse_temp};
    assign w_sp_x    = {setpoint[TEMP_W-1], setpoint};
    assign w_band_lo = w_sp_x - C_HYST;
    assign w_band_hi = w_sp_x + C_HYST;

    // Band entry conditions (from IDLE) and exit conditions (from HEAT/COOL).
    assign w_too_cold  = w_temp_x < w_band_lo;
    assign w_too_hot   = w_temp_x > w_band_hi;
    assign w_heat_done = w_temp_x >= w_sp_x;
    assign w_cool_done = w_temp_x <= w_sp_x;

    assign w_heat_ok = heat_permitted(mode);
    assign w_cool_ok = cool_permitted(mode);

    // Controller FSM with registered actuator enables and protection timers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_on_cnt  <= '0;
            r_off_cnt <= '0;
            r_heater  <= 1'b0;
            r_cooler  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Keep on_cnt at zero so it starts cleared on entry.
                    r_on_cnt  <= '0;
                    r_off_cnt <= '0;
                    if (sample_valid && w_heat_ok && w_too_cold) begin
                        r_state  <= ST_HEAT;
                        r_heater <= 1'b1;
                    end else if (sample_valid && w_cool_ok && w_too_hot) begin
                        r_state  <= ST_COOL;
                        r_cooler <= 1'b1;
                    end
                end

                ST_HEAT: begin
                    // Losing heat permission overrides the minimum on-time.
                    if (!w_heat_ok ||
                        (sample_valid && w_heat_done && r_on_cnt == C_ON_LAST)) begin
                        r_state   <= ST_REST;
                        r_heater  <= 1'b0;
                        r_cooler  <= 1'b0;
                        r_off_cnt <= '0;
                    end else if (r_on_cnt != C_ON_LAST) begin
                        r_on_cnt <= r_on_cnt + ON_W'(1);
                    end
                end

                ST_COOL: begin
                    // Losing cool permission overrides the minimum on-time.
                    if (!w_cool_ok ||
                        (sample_valid && w_cool_done && r_on_cnt == C_ON_LAST)) begin
                        r_state   <= ST_REST;
                        r_heater  <= 1'b0;
                        r_cooler  <= 1'b0;
                        r_off_cnt <= '0;
                    end else if (r_on_cnt != C_ON_LAST) begin
                        r_on_cnt <= r_on_cnt + ON_W'(1);
                    end
                end

                ST_REST: begin
                    // Samples and mode are ignored until the rest time expires.
                    r_on_cnt <= '0;
                    if (r_off_cnt == C_OFF_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_off_cnt <= r_off_cnt + OFF_W'(1);
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_on_cnt  <= '0;
                    r_off_cnt <= '0;
                    r_heater  <= 1'b0;
                    r_cooler  <= 1'b0;
                end
            endcase
        end
    end

    assign heater_on = r_heater;
    assign cooler_on = r_cooler;
    assign state_o   = r_state;

    temp_alarm_debounce #(
        .TEMP_W (TEMP_W),
        .THRESH (ALARM_HI),
        .CNT    (ALARM_CNT),
        .ABOVE  (1'b1)
    ) u_alarm_hi (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .temp         (greenhouse_temp),
        .alarm        (alarm_hi)
    );

    temp_alarm_debounce #(
        .TEMP_W (TEMP_W),
        .THRESH (ALARM_LO),
        .CNT    (ALARM_CNT),
        .ABOVE  (1'b0)
    ) u_alarm_lo (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .temp         (greenhouse_temp),
        .alarm        (alarm_lo)
    );

endmodule : greenhouse_temp_ctrl
`default_nettype wire

// File: tb/tb_greenhouse_temp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_greenhouse_temp_ctrl
// Purpose  : Self-checking bench for greenhouse_temp_ctrl: directed vector
//            table, hand-written timing/alarm sequences and a randomized run
//            compared against a timestamp-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_greenhouse_temp_ctrl;

    localparam int TEMP_W    = 8;
    localparam int HYST      = 2;
    localparam int MIN_ON    = 8;
    localparam int MIN_OFF   = 8;
    localparam int ALARM_HI  = 60;
    localparam int ALARM_LO  = -10;
    localparam int ALARM_CNT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_valid;
    logic [TEMP_W-1:0] greenhouse_temp;
    logic [TEMP_W-1:0] setpoint;
    logic [1:0]        mode;
    logic              heater_on;
    logic              cooler_on;
    logic [1:0]        state_o;
    logic              alarm_hi;
    logic              alarm_lo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    greenhouse_temp_ctrl #(
        .TEMP_W    (TEMP_W),
        .HYST      (HYST),
        .MIN_ON    (MIN_ON),
        .MIN_OFF   (MIN_OFF),
        .ALARM_HI  (ALARM_HI),
        .ALARM_LO  (ALARM_LO),
        .ALARM_CNT (ALARM_CNT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_valid    (sample_valid),
        .greenhouse_temp (greenhouse_temp),
        .setpoint        (setpoint),
        .mode            (mode),
        .heater_on       (heater_on),
        .cooler_on       (cooler_on),
        .state_o         (state_o),
        .alarm_hi        (alarm_hi),
        .alarm_lo        (alarm_lo)
    );

    // Reference model: state as a plain integer (0 idle, 1 heat, 2 cool,
    // 3 rest), the edge number at which it was entered, and unbounded runs
    // of consecutive qualifying samples for the alarms.
    int m_state = 0;
    int m_ent   = 0;
    int m_edge  = 0;
    int m_hirun = 0;
    int m_lorun = 0;

    task automatic model_edge(input bit r, input bit v, input int t,
                              input int sp, input bit [1:0] md);
        m_edge++;
        if (!r) begin
            m_state = 0; m_ent = m_edge; m_hirun = 0; m_lorun = 0;
        end else begin
            case (m_state)
                0: if (v) begin
                       if (md[0] && t < sp - HYST) begin m_state = 1; m_ent = m_edge; end
                       else if (md[1] && t > sp + HYST) begin m_state = 2; m_ent = m_edge; end
                   end
                1: if (!md[0] || (v && t >= sp && m_edge - m_ent >= MIN_ON)) begin
                       m_state = 3; m_ent = m_edge;
                   end
                2: if (!md[1] || (v && t <= sp && m_edge - m_ent >= MIN_ON)) begin
                       m_state = 3; m_ent = m_edge;
                   end
                default: if (m_edge - m_ent >= MIN_OFF) begin
                       m_state = 0; m_ent = m_edge;
                   end
            endcase
            if (v) begin
                m_hirun = (t > ALARM_HI) ? m_hirun + 1 : 0;
                m_lorun = (t < ALARM_LO) ? m_lorun + 1 : 0;
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic step(input bit r, input bit v, input int t,
                        input int sp, input bit [1:0] md);
        rst             = r;
        sample_valid    = v;
        greenhouse_temp = TEMP_W'(t);
        setpoint        = TEMP_W'(sp);
        mode            = md;
        @(posedge clk);
        model_edge(r, v, t, sp, md);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        bit       r;
        bit       v;
        int       t;
        int       sp;
        bit [1:0] md;
        bit       eh;
        bit       ec;
        int       es;
        bit       ahi;
        bit       alo;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int t, sp;
        bit [1:0] md;
        bit r, v;

        //            r  v    t    sp  md  eh ec es hi lo
        tbl[0]  = '{1'b0,1'b0,   0,  20,2'b11,1'b0,1'b0,0,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,  22,  20,2'b11,1'b0,1'b0,0,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b1,  18,  20,2'b11,1'b0,1'b0,0,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,  23,  20,2'b11,1'b0,1'b1,2,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b0,  23,  20,2'b01,1'b0,1'b0,3,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,  20,  20,2'b11,1'b0,1'b0,0,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b1,  17,  20,2'b11,1'b1,1'b0,1,1'b0,1'b0};
        tbl[7]  = '{1'b1,1'b1,  21,  20,2'b11,1'b1,1'b0,1,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,  21,  20,2'b11,1'b0,1'b0,0,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b1,-128,-128,2'b11,1'b0,1'b0,0,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b1, 127,-128,2'b00,1'b0,1'b0,0,1'b0,1'b0};
        tbl[11] = '{1'b1,1'b1, 127, 127,2'b11,1'b0,1'b0,0,1'b0,1'b0};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].t, tbl[i].sp, tbl[i].md);
            check($sformatf("vec%0d heater", i), int'(heater_on), int'(tbl[i].eh));
            check($sformatf("vec%0d cooler", i), int'(cooler_on), int'(tbl[i].ec));
            check($sformatf("vec%0d state",  i), int'(state_o),   tbl[i].es);
            check($sformatf("vec%0d alm_hi", i), int'(alarm_hi),  int'(tbl[i].ahi));
            check($sformatf("vec%0d alm_lo", i), int'(alarm_lo),  int'(tbl[i].alo));
        end

        // Heater minimum on-time then exact rest length.
        step(1'b0, 1'b0, 20, 20, 2'b11);
        step(1'b1, 1'b1, 17, 20, 2'b11);
        check("heat_entry", int'(state_o), 1);
        cnt = 0;
        while (state_o == 2'd1 && cnt < 40) begin
            cnt++;
            step(1'b1, 1'b1, 21, 20, 2'b11);
        end
        check("heat_on_cycles", cnt, MIN_ON);
        check("heat_exit_heater", int'(heater_on), 0);
        cnt = 0;
        while (state_o == 2'd3 && cnt < 40) begin
            cnt++;
            step(1'b1, 1'b1, 17, 20, 2'b11);
        end
        check("heat_rest_cycles", cnt, MIN_OFF);
        check("heat_rest_to_idle", int'(state_o), 0);

        // Cooling safety override then rest length, then heat re-entry.
        step(1'b0, 1'b0, 20, 20, 2'b11);
        step(1'b1, 1'b1, 23, 20, 2'b11);
        check("cool_entry", int'(cooler_on), 1);
        step(1'b1, 1'b0, 23, 20, 2'b01);
        check("override_cooler", int'(cooler_on), 0);
        check("override_state", int'(state_o), 3);
        cnt = 0;
        while (state_o == 2'd3 && cnt < 40) begin
            cnt++;
            step(1'b1, 1'b1, 10, 20, 2'b01);
        end
        check("override_rest_cycles", cnt, MIN_OFF);
        check("override_idle", int'(state_o), 0);
        step(1'b1, 1'b1, 10, 20, 2'b01);
        check("after_rest_heat", int'(state_o), 1);

        // High alarm: broken run never alarms; gapped run of four does.
        step(1'b0, 1'b0, 20, 20, 2'b00);
        step(1'b1, 1'b1, 61, 20, 2'b00); check("hi_run1", int'(alarm_hi), 0);
        step(1'b1, 1'b1, 61, 20, 2'b00); check("hi_run2", int'(alarm_hi), 0);
        step(1'b1, 1'b1, 61, 20, 2'b00); check("hi_run3", int'(alarm_hi), 0);
        step(1'b1, 1'b1, 59, 20, 2'b00); check("hi_break", int'(alarm_hi), 0);
        step(1'b1, 1'b1, 61, 20, 2'b00); check("hi_after_break", int'(alarm_hi), 0);
        step(1'b1, 1'b1, 61, 20, 2'b00);
        step(1'b1, 1'b0, 0, 20, 2'b00);
        step(1'b1, 1'b1, 61, 20, 2'b00); check("hi_third", int'(alarm_hi), 0);
        step(1'b1, 1'b1, 61, 20, 2'b00); check("hi_fourth", int'(alarm_hi), 1);
        step(1'b1, 1'b0, 0, 20, 2'b00);  check("hi_hold", int'(alarm_hi), 1);
        step(1'b1, 1'b1, 60, 20, 2'b00); check("hi_clear_at_60", int'(alarm_hi), 0);

        // Low alarm with non-valid gaps between the samples.
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0, 50, 20, 2'b00);
            step(1'b1, 1'b1, -11, 20, 2'b00);
            check($sformatf("lo_sample%0d", k), int'(alarm_lo), (k == 4) ? 1 : 0);
        end
        check("lo_hi_quiet", int'(alarm_hi), 0);

        // Randomized run against the reference model.
        sp = 20; md = 2'b11;
        step(1'b0, 1'b0, 20, sp, md);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 299) != 0);
            v  = $urandom_range(0, 1) == 1;
            t  = int'($urandom_range(0, 60)) - 10;
            if ($urandom_range(0, 15) == 0) t = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 63) == 0) sp = int'($urandom_range(0, 40));
            if ($urandom_range(0, 63) == 0) sp = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 47) == 0) md = 2'($urandom_range(0, 3));
            step(r, v, t, sp, md);
            check("rand_outputs",
                  int'({heater_on, cooler_on, state_o, alarm_hi, alarm_lo}),
                  int'({m_state == 1, m_state == 2, 2'(m_state),
                        m_hirun >= ALARM_CNT, m_lorun >= ALARM_CNT}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_greenhouse_temp_ctrl
`default_nettype wire

// File: doc/greenhouse_temp_ctrl.md
Name: greenhouse_temp_ctrl

Overview:
Parametrised single-zone greenhouse climate controller, the successor to the fixed-width `control` block.
- Samples a signed temperature under a valid strobe and compares it against a runtime setpoint with a hysteresis band.
- Drives mutually exclusive heater and cooler enables, with minimum-on and minimum-off (compressor/element protection) timers.
- Raises debounced high/low temperature alarms.
- Sits between the sensor front-end and the actuator drivers.

Parameters:
- TEMP_W, 8, width of signed temperature and setpoint.
- HYST, 2, hysteresis half-band in temperature LSBs (non-negative).
- MIN_ON, 8, minimum actuator on-time in clock cycles (>=1).
- MIN_OFF, 8, minimum rest time after any actuator turn-off, in clock cycles (>=1).
- ALARM_HI, 60, high alarm threshold (signed).
- ALARM_LO, -10, low alarm threshold (signed).
- ALARM_CNT, 4, consecutive qualifying samples required to assert an alarm (>=1).

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-low reset.
- sample_valid, input, 1, greenhouse_temp is valid this cycle.
- greenhouse_temp, input, TEMP_W, signed measured temperature.
- setpoint, input, TEMP_W, signed target temperature; sampled only on sample_valid cycles.
- mode, input, 2, actuator mode: 00 off, 01 heat-only, 10 cool-only, 11 auto.
- heater_on, output, 1, heater enable (registered).
- cooler_on, output, 1, cooler enable (registered).
- state_o, output, 2, FSM state: 00 IDLE, 01 HEAT, 10 COOL, 11 REST.
- alarm_hi, output, 1, debounced over-temperature alarm.
- alarm_lo, output, 1, debounced under-temperature alarm.

Behaviour:
- Reset (rst==0 at a rising edge):
  - state IDLE; on/off counters 0; alarm counters 0.
  - heater_on, cooler_on, alarm_hi, alarm_lo all 0.
  - Reset mid-HEAT/COOL drops actuators on that same edge, ignoring MIN_ON/MIN_OFF.
- Arithmetic:
  - Temperature, setpoint, setpoint-HYST and setpoint+HYST are sign-extended to TEMP_W+1 bits before comparing.
  - No wrap at extremes, e.g. setpoint = -128 with HYST = 2 compares against -130.
- Outputs are registered from the state: heater_on = (state==HEAT), cooler_on = (state==COOL).
- Latency: a sample_valid at edge N that changes state is reflected on the outputs after edge N (visible in cycle N+1).
- IDLE:
  - On sample_valid, if mode[0] and temp < setpoint-HYST: go to HEAT.
  - Else if mode[1] and temp > setpoint+HYST: go to COOL.
  - Otherwise stay. Both conditions cannot be true together.
- HEAT / COOL (shared rules):
  - on_cnt clears on entry and increments every cycle, saturating at MIN_ON-1.
  - Leave for REST when sample_valid, the exit condition holds and on_cnt==MIN_ON-1.
  - HEAT exit condition: temp >= setpoint. COOL exit condition: temp <= setpoint.
- Safety override: if mode stops permitting the active actuator (HEAT needs mode[0], COOL needs mode[1]), go to REST on the next edge regardless of on_cnt.
- No direct HEAT<->COOL transition; REST always sits between them.
- REST:
  - off_cnt clears on entry and increments every cycle.
  - Go to IDLE on the edge where off_cnt==MIN_OFF-1, so REST lasts exactly MIN_OFF cycles.
  - Samples and mode changes are ignored while in REST.
- Alarms (independent of the FSM and mode; updated only on sample_valid):
  - hi_cnt increments (saturating at ALARM_CNT) when temp > ALARM_HI, and clears to 0 otherwise.
  - alarm_hi = (hi_cnt==ALARM_CNT), registered; it clears on the first non-qualifying valid sample.
  - The low alarm mirrors this using temp < ALARM_LO.
  - A non-valid cycle holds both counters and both alarms.
- Setpoint or mode changes on non-valid cycles only matter at the next valid sample. The exception is the safety override, which acts on any cycle.

Decomposition:
- greenhouse_pkg holds:
  - the state typedef (IDLE, HEAT, COOL, REST with the encodings above);
  - the mode constants MODE_OFF, MODE_HEAT, MODE_COOL, MODE_AUTO.
- Sub-module temp_alarm_debounce:
  - parameters TEMP_W, THRESH, CNT, ABOVE (1 = greater-than, 0 = less-than);
  - ports clk, rst, sample_valid, temp, alarm;
  - instantiated twice (high and low).

Test Plan:
- Defaults, setpoint=20, mode=11, valid temp=17 at edge N -> heater_on=1 and state_o=01 from cycle N+1; cooler_on stays 0.
- In HEAT, valid temp=21 at 3 cycles after entry -> heater stays on. Valid temp=21 at cycle >=7 after entry -> heater_on=0, state_o=11, then exactly 8 cycles later state_o=00.
- In IDLE, temp=22 valid (within band 18..22) -> no change. temp=23 -> cooler_on=1. mode forced to 01 mid-COOL -> cooler_on=0 next cycle, REST for 8 cycles.
- Valid temp=61 four times in a row -> alarm_hi=1 after the 4th. 61,61,61,59,61 -> alarm_hi never set. Once set, one valid 60 -> alarm_hi=0.
- Valid temp=-11 x4 -> alarm_lo=1; a non-valid cycle between samples does not break the count.
- rst=0 for one edge during HEAT -> all outputs 0, state IDLE on that edge. setpoint=-128, temp=-128, mode=11 -> no actuation (no wrap).
